// File: rtl/mem_pkg.sv
// Shared types and address constants for the block-fill memory responder.
// Blocks are 16 bytes of 2-byte words; the block base is the address with the low nibble cleared.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_WAIT
  } state_t;

  localparam int          WORD_BYTES  = 2;
  localparam int          BLOCK_BYTES = 16;
  localparam logic [15:0] BLOCK_MASK  = ~16'(BLOCK_BYTES - 1);

endpackage

// File: rtl/mem_array.sv
// DEPTH x 16 single-port array: one-cycle registered read, write enable; contents are never reset.
// Only the read-data register is reset, so the responder's data output reads zero during reset.
module mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];
  logic [15:0] rdata_q;

  // A write seen while reset is held is dropped, so a pending write can never land.
  always_ff @(posedge clk) begin
    if (we && rst_n) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (!we) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_fill_responder.sv
// One-at-a-time memory responder: block read streams WORDS beats after LATENCY cycles, or single-word write with ack.
// req_ready only in IDLE; the burst never stalls, so the requester must sink every beat.
module mem_fill_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int WORDS   = 8,
  parameter int DEPTH   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic [15:0] rsp_addr,
  output logic        rsp_last,
  output logic        wr_ack,
  output logic        busy
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] LAT      = 4'(LATENCY);
  localparam logic [3:0] LAST_OFF = 4'((WORDS - 1) * WORD_BYTES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  off_q, off_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_ack_q, wr_ack_d;
  logic        mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        unused_addr_bits;

  // The array is addressed with next-state values so each beat's word is already
  // registered when that beat is presented.  A counter value of 2 marks the edge on
  // which the first beat (or the write) lands, giving LATENCY cycles from accept.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    off_d     = 4'd0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_we    = 1'b0;
    mem_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          cnt_d  = LAT;
          if (req_write) begin
            wdata_d   = req_wdata;
            mem_wdata = req_wdata;
            mem_we    = (LAT == 4'd1);
            state_d   = WR_WAIT;
          end else begin
            state_d = (LAT == 4'd1) ? RD_BURST : RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd2) begin
          state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        if (off_q == LAST_OFF) begin
          state_d = IDLE;
        end else begin
          off_d = off_q + 4'(WORD_BYTES);
        end
      end
      WR_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd2) begin
          mem_we = 1'b1;
        end else if (cnt_q == 4'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_ack_d = mem_we;
    mem_addr = mem_we ? addr_d : ((addr_d & BLOCK_MASK) | {12'h000, off_d});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      off_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  mem_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (mem_we),
    .addr (mem_addr[AW:1]),
    .wdata(mem_wdata),
    .rdata(rsp_data)
  );

  assign unused_addr_bits = ^{mem_addr[15:AW+1], mem_addr[0]};

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RD_BURST);
  assign rsp_addr  = (addr_q & BLOCK_MASK) | {12'h000, off_q};
  assign rsp_last  = rsp_valid && (off_q == LAST_OFF);
  assign wr_ack    = wr_ack_q;

endmodule

// File: tb/tb_mem_fill_responder.sv
// Bench for mem_fill_responder: LATENCY=4 and LATENCY=1 instances checked cycle by cycle against a word-array model.
module tb_mem_fill_responder;

  localparam int DEPTH = 1024;
  localparam int LAT0  = 4;
  localparam int LAT1  = 1;

  logic        clk;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_data  [2];
  logic [15:0] rsp_addr  [2];
  logic        rsp_last  [2];
  logic        wr_ack    [2];
  logic        busy      [2];

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] ref_mem [2][DEPTH];
  logic [15:0] got_addr [8];
  logic [15:0] got_data [8];
  bit          hold_next = 1'b0;
  logic [15:0] next_addr = 16'h0000;
  int          abort_at  = -1;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          beat;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl [16];

  mem_fill_responder #(.LATENCY(LAT0), .WORDS(8), .DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_addr(rsp_addr[0]),
    .rsp_last(rsp_last[0]), .wr_ack(wr_ack[0]), .busy(busy[0])
  );

  mem_fill_responder #(.LATENCY(LAT1), .WORDS(8), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_addr(rsp_addr[1]),
    .rsp_last(rsp_last[1]), .wr_ack(wr_ack[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input int u);
    chk("rst_req_ready", 32'(req_ready[u]), 32'd1);
    chk("rst_busy",      32'(busy[u]),      32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid[u]), 32'd0);
    chk("rst_rsp_last",  32'(rsp_last[u]),  32'd0);
    chk("rst_wr_ack",    32'(wr_ack[u]),    32'd0);
    chk("rst_rsp_data",  32'(rsp_data[u]),  32'd0);
    chk("rst_rsp_addr",  32'(rsp_addr[u]),  32'd0);
  endtask

  // Issue one request on instance u and check every cycle until it has completed.
  // Sample index k counts falling edges after the accepting rising edge.
  task automatic do_req(input int u, input bit wr, input logic [15:0] a, input logic [15:0] wd);
    int lat, n, j, kmax;
    logic [15:0] base, exp_a;
    lat = (u == 0) ? LAT0 : LAT1;
    n = 0;
    while (req_ready[u] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(n < 200), 32'd1);
    if (n >= 200) return;
    req_valid[u] = 1'b1;
    req_write[u] = wr;
    req_addr[u]  = a;
    req_wdata[u] = wd;
    @(negedge clk);
    if (hold_next) begin
      req_write[u] = 1'b0;
      req_addr[u]  = next_addr;
    end else begin
      req_valid[u] = 1'b0;
    end
    base = {a[15:4], 4'h0};
    kmax = wr ? lat : lat + 7;
    for (int k = 0; k <= kmax; k++) begin
      chk("req_ready", 32'(req_ready[u]), 32'(k == kmax));
      chk("busy",      32'(busy[u]),      32'(k != kmax));
      if (wr) begin
        chk("wr_ack",       32'(wr_ack[u]),    32'(k == lat - 1));
        chk("rsp_valid_wr", 32'(rsp_valid[u]), 32'd0);
      end else begin
        j = k - (lat - 1);
        chk("rsp_valid", 32'(rsp_valid[u]), 32'(j >= 0 && j < 8));
        chk("wr_ack_rd", 32'(wr_ack[u]),    32'd0);
        if (j >= 0 && j < 8) begin
          exp_a = base + 16'(2 * j);
          chk("rsp_addr", 32'(rsp_addr[u]), 32'(exp_a));
          chk("rsp_data", 32'(rsp_data[u]), 32'(ref_mem[u][(exp_a >> 1) % DEPTH]));
          chk("rsp_last", 32'(rsp_last[u]), 32'(j == 7));
          got_addr[j] = rsp_addr[u];
          got_data[j] = rsp_data[u];
        end
      end
      if (k == abort_at) return;
      if (wr && k == lat - 1) ref_mem[u][(a >> 1) % DEPTH] = wd;
      if (k < kmax) @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0;
      req_write[u] = 1'b0;
      req_addr[u]  = 16'h0000;
      req_wdata[u] = 16'h0000;
    end
    for (int i = 0; i < 8; i++) begin
      got_addr[i] = 16'h0000;
      got_data[i] = 16'h0000;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill the whole backing array so every later read is fully predictable.
    for (int i = 0; i < DEPTH; i++) do_req(0, 1'b1, 16'(2 * i), 16'($urandom));

    for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 16'h1230 + 16'(2 * i), 16'hA000 + 16'(i), 0, 16'h0, 16'h0};
    tbl[8]  = '{1'b0, 16'h1236, 16'h0000, 0, 16'h1230, 16'hA000};
    tbl[9]  = '{1'b0, 16'h1236, 16'h0000, 7, 16'h123E, 16'hA007};
    tbl[10] = '{1'b1, 16'h0043, 16'hBEEF, 0, 16'h0, 16'h0};
    tbl[11] = '{1'b0, 16'h0040, 16'h0000, 1, 16'h0042, 16'hBEEF};
    tbl[12] = '{1'b1, 16'hFFFE, 16'h5A5A, 0, 16'h0, 16'h0};
    tbl[13] = '{1'b0, 16'hFFFA, 16'h0000, 7, 16'hFFFE, 16'h5A5A};
    tbl[14] = '{1'b1, 16'h0802, 16'h7777, 0, 16'h0, 16'h0};
    tbl[15] = '{1'b0, 16'h0000, 16'h0000, 1, 16'h0002, 16'h7777};
    for (int i = 0; i < 16; i++) begin
      do_req(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      if (!tbl[i].wr) begin
        chk("tbl_addr", 32'(got_addr[tbl[i].beat]), 32'(tbl[i].exp_addr));
        chk("tbl_data", 32'(got_data[tbl[i].beat]), 32'(tbl[i].exp_data));
      end
    end
    do_req(0, 1'b0, 16'hFFFA, 16'h0000);
    chk("wrap_first", 32'(got_addr[0]), 32'h0000FFF0);

    // Second read held on req_valid across the whole first burst.
    hold_next = 1'b1;
    next_addr = 16'h1238;
    do_req(0, 1'b0, 16'h0040, 16'h0000);
    hold_next = 1'b0;
    do_req(0, 1'b0, 16'h1238, 16'h0000);
    chk("hold_second", 32'(got_data[0]), 32'h0000A000);

    // Reset during beat 3 of a burst, then a clean read.
    abort_at = (LAT0 - 1) + 3;
    do_req(0, 1'b0, 16'h1236, 16'h0000);
    abort_at = -1;
    pulse_reset();
    do_req(0, 1'b0, 16'h1236, 16'h0000);
    chk("post_reset_read", 32'(got_data[3]), 32'h0000A003);

    // Reset before a pending write lands: the word keeps its old value.
    abort_at = 1;
    do_req(0, 1'b1, 16'h1232, 16'hDEAD);
    abort_at = -1;
    pulse_reset();
    do_req(0, 1'b0, 16'h1230, 16'h0000);
    chk("discarded_write", 32'(got_data[1]), 32'h0000A001);

    // Minimum latency instance.
    for (int i = 0; i < 8; i++) do_req(1, 1'b1, 16'h0100 + 16'(2 * i), 16'hC000 + 16'(i));
    do_req(1, 1'b0, 16'h0106, 16'h0000);
    chk("lat1_first_addr", 32'(got_addr[0]), 32'h00000100);
    chk("lat1_last_data",  32'(got_data[7]), 32'h0000C007);

    for (int i = 0; i < 150; i++) do_req(0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_fill_responder.md
# mem_fill_responder

Memory-side responder for the cache block-fill protocol. It accepts one request at a time from a cache controller: either a 16-byte block read or a single-word write. For a read, it waits a fixed access latency, then streams the block as eight consecutive 16-bit beats with `rsp_valid`, starting at the block-aligned base. It sits between the cache fill controllers and the main-memory array and serves as the system's multi-cycle memory.

## Interface
- `LATENCY`, 4: cycles from request accept to first read beat, or to write ack; legal 1..15.
- `WORDS`, 8: beats per block; each word is 2 bytes, so a block is 16 bytes.
- `DEPTH`, 1024: words held in the backing array.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request; high only in IDLE.
- `req_write`  in  1  1 = single-word write, 0 = block read.
- `req_addr`  in  16  byte address.
- `req_wdata`  in  16  write data.
- `rsp_valid`  out  1  read beat valid this cycle.
- `rsp_data`  out  16  read beat data.
- `rsp_addr`  out  16  byte address of the current beat.
- `rsp_last`  out  1  final beat of the block.
- `wr_ack`  out  1  one-cycle pulse when a write completes.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, RD_WAIT, RD_BURST, WR_WAIT.
- IDLE: `req_ready`=1. A request is accepted on a clock edge where `req_valid` is high.
  - On accept, `req_addr` is latched and a latency counter is loaded with `LATENCY`.
  - A read goes to RD_WAIT. A write latches `req_wdata` and goes to WR_WAIT.
- RD_WAIT: the counter decrements each cycle. On expiry the FSM enters RD_BURST with beat offset 0.
- RD_BURST: `rsp_valid`=1 every cycle, with no stalls.
  - `rsp_addr` = `{addr[15:4], offset}`, where offset steps 0, 2, …, 14.
  - `rsp_data` = array word at `rsp_addr`.
  - `rsp_last`=1 on offset 14; the FSM then returns to IDLE.
- WR_WAIT: the counter counts down. On expiry the array word is written, `wr_ack` pulses for one cycle, and the FSM returns to IDLE.
- Address arithmetic:
  - Block base = `addr & 16'hFFF0`. The offset adds into bits [3:0] only and never carries into [15:4], so a fill at 0xFFFA covers 0xFFF0..0xFFFE and does not wrap to 0x0000.
  - Array index = `addr[log2(DEPTH):1]`. Higher address bits alias. Bit 0 is ignored, so writes are always word-aligned.
- `req_valid` while not in IDLE is ignored (`req_ready`=0). The requester holds its request until accepted.
- The array has no reset; its contents survive `rst_n`.

## Timing
- Reset (async, `rst_n`=0): state IDLE, counter 0, offset 0.
  - Output values: `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_last`=0, `wr_ack`=0, `rsp_data`=0, `rsp_addr`=0.
  - These take effect immediately on assertion, including mid-burst. Any in-flight read is dropped and any pending write is discarded without writing.
- Read accepted at edge E0: `rsp_valid` is high for exactly 8 cycles, starting in the cycle after edge E0+`LATENCY`−1. With `LATENCY`=4, the first beat follows edge E3 and `rsp_last` follows edge E10.
- Write accepted at E0: the array is updated and `wr_ack` pulses in the cycle after edge E0+`LATENCY`−1.
- `req_ready` rises in the cycle after `rsp_last` or `wr_ack`, so there is no zero-bubble back-to-back accept.
- A write followed by a read of the same word returns the new data.
- All outputs are registered; there is no combinational path from `req_*` to `rsp_*`.

## Structure
- Shared package `mem_pkg` holds the state enum (`IDLE`, `RD_WAIT`, `RD_BURST`, `WR_WAIT`), `WORD_BYTES`=2, `BLOCK_BYTES`=16, and `BLOCK_MASK`=16'hFFF0.
- One sub-module, `mem_array`: DEPTH×16, synchronous single-port, one-cycle read, write enable. The FSM issues each read address one cycle ahead so that beats are continuous.
- The latency counter and the beat-offset counter are separate 4-bit registers inside the top module.

## Test plan
- Preload 0x1230..0x123E with 0xA000..0xA007, then read 0x1236 → 8 consecutive beats after 4 cycles, `rsp_addr` 0x1230..0x123E, data 0xA000..0xA007, `rsp_last` only on 0x123E.
- Write 0xBEEF to 0x0043 → `wr_ack` pulses 4 cycles after accept; a following read of 0x0040 returns beat 1 = 0xBEEF.
- Hold `req_valid` with a second read across the first burst → `req_ready`=0 throughout; the second request is accepted the cycle after `rsp_last`; no beats overlap.
- Read 0xFFFA → `rsp_addr` 0xFFF0..0xFFFE, no carry into 0x0000.
- Assert `rst_n`=0 during beat 3 → `rsp_valid`/`busy` go to 0 asynchronously; after release `req_ready`=1 and a new read returns correct data.
- `LATENCY`=1 → first beat in the cycle after accept; a write with `LATENCY`=1 gives `wr_ack` in the cycle after accept.
